// File: rtl/vector_reverse_arbiter.sv
// Round-robin arbiter that shares one registered bit-reverse stage among NUM_REQ
// requesters. One response slot carries the reversed word and its requester ID.
module vector_reverse_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [ID_W-1:0]          rsp_id,
   input  logic                     rsp_ready,
   output logic [15:0]              served_cnt
);

   typedef enum logic {EMPTY, FULL} slot_state_e;

   slot_state_e      state, next_state;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  grant_id;
   logic             accept;
   logic             slot_free;
   logic [WIDTH-1:0] words [NUM_REQ];
   logic [WIDTH-1:0] grant_word;
   logic [WIDTH-1:0] grant_rev;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign words[g] = req_data[g*WIDTH +: WIDTH];
   end

   for (genvar b = 0; b < WIDTH; b++) begin : g_reverse
      assign grant_rev[b] = grant_word[WIDTH-1-b];
   end

   // The slot can take a new word when empty or when its current word drains now.
   assign slot_free  = (state == EMPTY) || rsp_ready;
   assign rsp_valid  = (state == FULL);
   assign grant_word = words[grant_id];

   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      int sum;
      req_ready = '0;
      grant_id  = '0;
      accept    = 1'b0;
      sum       = 0;
      if (rst_n && slot_free) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            if (!accept && req_valid[ID_W'(sum)]) begin
               accept                 = 1'b1;
               req_ready[ID_W'(sum)]  = 1'b1;
               grant_id               = ID_W'(sum);
            end
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         EMPTY:   if (accept) next_state = FULL;
         FULL:    if (rsp_ready && !accept) next_state = EMPTY;
         default: next_state = EMPTY;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= EMPTY;
      else        state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_data   <= '0;
         rsp_id     <= '0;
         rr_ptr     <= '0;
         served_cnt <= '0;
      end else if (accept) begin
         rsp_data   <= grant_rev;
         rsp_id     <= grant_id;
         rr_ptr     <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
         served_cnt <= served_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_vector_reverse_arbiter.sv
// Directed bench for vector_reverse_arbiter: reversal, round-robin order,
// backpressure without bubbles, and mid-operation reset.
module tb_vector_reverse_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_id;
   logic        rsp_ready;
   logic [15:0] served_cnt;

   int checks = 0;
   int errors = 0;

   vector_reverse_arbiter #(.NUM_REQ(4), .WIDTH(8), .ID_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .rsp_ready  (rsp_ready),
      .served_cnt (served_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic send_single(input int id, input logic [7:0] word,
                              input logic [7:0] exp, input logic [15:0] exp_cnt);
      logic [3:0] onehot;
      onehot = 4'b0001 << id;
      req_data[id*8 +: 8] = word;
      req_valid = onehot;
      #1;
      check("single_grant", 32'(req_ready), 32'(onehot));
      tick();
      req_valid = '0;
      req_data  = '0;
      check("single_valid", 32'(rsp_valid), 32'd1);
      check("single_data",  32'(rsp_data),  32'(exp));
      check("single_id",    32'(rsp_id),    32'(id));
      check("single_cnt",   32'(served_cnt), 32'(exp_cnt));
      tick();
      check("single_drain", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      logic [7:0] rr_exp_data [5];
      logic [1:0] rr_exp_id   [5];
      rr_exp_data = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h80};
      rr_exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b1;

      // Reset then idle
      tick();
      check("rst_ready_low", 32'(req_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_data",  32'(rsp_data),  32'd0);
      check("rst_id",    32'(rsp_id),    32'd0);
      check("rst_cnt",   32'(served_cnt), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("idle_valid", 32'(rsp_valid), 32'd0);
         check("idle_ready", 32'(req_ready), 32'd0);
         check("idle_cnt",   32'(served_cnt), 32'd0);
      end

      // Single requests; order leaves the pointer back at 0
      send_single(2, 8'h12, 8'h48, 16'd1);
      send_single(0, 8'h01, 8'h80, 16'd2);
      send_single(1, 8'hC0, 8'h03, 16'd3);
      send_single(3, 8'hA5, 8'hA5, 16'd4);

      // Round-robin fairness from a clean reset
      do_reset();
      req_data  = {8'h08, 8'h04, 8'h02, 8'h01};
      req_valid = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         #1;
         check("rr_grant", 32'(req_ready), 32'(4'b0001 << rr_exp_id[n]));
         tick();
         check("rr_valid", 32'(rsp_valid), 32'd1);
         check("rr_id",    32'(rsp_id),    32'(rr_exp_id[n]));
         check("rr_data",  32'(rsp_data),  32'(rr_exp_data[n]));
         if (n == 3) check("rr_cnt4", 32'(served_cnt), 32'd4);
      end
      req_valid = '0;
      check("rr_cnt5", 32'(served_cnt), 32'd5);

      // Backpressure: drain, load 0x0F from requester 1, then stall
      tick();
      check("bp_empty", 32'(rsp_valid), 32'd0);
      rsp_ready = 1'b0;
      req_data  = {8'h00, 8'h33, 8'h0F, 8'h00};
      req_valid = 4'b0010;
      #1;
      check("bp_grant1", 32'(req_ready), 32'b0010);
      tick();
      req_valid = 4'b0100;
      check("bp_load", 32'(rsp_data), 32'hF0);
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_ready_low", 32'(req_ready), 32'd0);
         tick();
         check("bp_hold_data",  32'(rsp_data),  32'hF0);
         check("bp_hold_id",    32'(rsp_id),    32'd1);
         check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_regrant", 32'(req_ready), 32'b0100);
      tick();
      req_valid = '0;
      check("bp_nobubble_valid", 32'(rsp_valid), 32'd1);
      check("bp_new_data",       32'(rsp_data),  32'hCC);
      check("bp_new_id",         32'(rsp_id),    32'd2);
      check("bp_cnt",            32'(served_cnt), 32'd7);

      // Mid-operation reset with a response held and all requesters active
      rsp_ready = 1'b0;
      req_data  = {8'h08, 8'h04, 8'h02, 8'h01};
      req_valid = 4'b1111;
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      #1;
      check("mrst_ready_low", 32'(req_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      check("mrst_valid", 32'(rsp_valid), 32'd0);
      check("mrst_data",  32'(rsp_data),  32'd0);
      check("mrst_id",    32'(rsp_id),    32'd0);
      check("mrst_cnt",   32'(served_cnt), 32'd0);
      #1;
      check("mrst_grant0", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
      check("mrst_first_id",   32'(rsp_id),    32'd0);
      check("mrst_first_data", 32'(rsp_data),  32'h80);
      check("mrst_first_cnt",  32'(served_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
